slot_rng_system: RTL and testbench

//  Three-reel random-number source for the casino slot machine. Three independent
//  8-bit maximal-length LFSRs advance one step per clock while the player holds the

---
 rtl/slot_rng_system.sv | 53 +++++
 tb/tb_slot_rng_system.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/slot_rng_system.sv
// Three-reel slot-machine random source: three 8-bit maximal-length LFSRs
// stepping together while the spin button is held, frozen otherwise.
module slot_rng_system #(
    parameter logic [7:0] SEED1 = 8'hA5,
    parameter logic [7:0] SEED2 = 8'h3C,
    parameter logic [7:0] SEED3 = 8'h5A
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button_press,
    output logic [2:0] rng1,
    output logic [2:0] rng2,
    output logic [2:0] rng3
);

    logic [7:0] lfsr1_q, lfsr2_q, lfsr3_q;
    logic [7:0] lfsr1_d, lfsr2_d, lfsr3_d;

    // x^8+x^6+x^5+x^4+1; an all-zero state is forced out to 8'h01.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        logic fb;
        fb = s[7] ^ s[5] ^ s[4] ^ s[3];
        if (s == 8'h00) begin
            return 8'h01;
        end
        return {s[6:0], fb};
    endfunction

    always_comb begin
        lfsr1_d = lfsr_step(lfsr1_q);
        lfsr2_d = lfsr_step(lfsr2_q);
        lfsr3_d = lfsr_step(lfsr3_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr1_q <= SEED1;
            lfsr2_q <= SEED2;
            lfsr3_q <= SEED3;
            rng1    <= 3'b000;
            rng2    <= 3'b000;
            rng3    <= 3'b000;
        end else if (button_press) begin
            lfsr1_q <= lfsr1_d;
            lfsr2_q <= lfsr2_d;
            lfsr3_q <= lfsr3_d;
            rng1    <= lfsr1_d[2:0];
            rng2    <= lfsr2_d[2:0];
            rng3    <= lfsr3_d[2:0];
        end
    end

endmodule

// File: tb/tb_slot_rng_system.sv
// Self-checking bench for slot_rng_system: per-cycle model comparison plus
// hand-computed checkpoints (first step, full period, async reset, lock-up guard).
module tb_slot_rng_system;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       button_press = 1'b0;
    logic [2:0] rng1, rng2, rng3;
    logic [2:0] z_rng1, z_rng2, z_rng3;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    logic [7:0] m_lfsr [3];
    logic [2:0] m_rng  [3];
    logic [7:0] m_next;

    always #5 clk = ~clk;

    slot_rng_system dut (
        .clk          (clk),
        .reset        (reset),
        .button_press (button_press),
        .rng1         (rng1),
        .rng2         (rng2),
        .rng3         (rng3)
    );

    // Out-of-range seeds, used only to exercise the all-zero guard.
    slot_rng_system #(
        .SEED1 (8'h00),
        .SEED2 (8'h01),
        .SEED3 (8'h80)
    ) dut_z (
        .clk          (clk),
        .reset        (reset),
        .button_press (button_press),
        .rng1         (z_rng1),
        .rng2         (z_rng2),
        .rng3         (z_rng3)
    );

    // Taps 7,5,4,3 as a parity mask; shift left and insert feedback at bit 0.
    function automatic logic [7:0] model_step(input logic [7:0] s);
        logic fb;
        if (s == 8'h00) return 8'h01;
        fb = ^(s & 8'hB8);
        return 8'((s << 1) | {7'd0, fb});
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_lfsr[0] <= 8'hA5;
            m_lfsr[1] <= 8'h3C;
            m_lfsr[2] <= 8'h5A;
            for (int i = 0; i < 3; i++) m_rng[i] <= 3'd0;
        end else if (button_press) begin
            for (int i = 0; i < 3; i++) begin
                m_next = model_step(m_lfsr[i]);
                m_lfsr[i] <= m_next;
                m_rng[i]  <= m_next[2:0];
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("rng1_vs_model", {5'd0, rng1}, {5'd0, m_rng[0]});
            check("rng2_vs_model", {5'd0, rng2}, {5'd0, m_rng[1]});
            check("rng3_vs_model", {5'd0, rng3}, {5'd0, m_rng[2]});
            checks++;
            if (dut.lfsr1_q == 8'h00 || dut.lfsr2_q == 8'h00 || dut.lfsr3_q == 8'h00) begin
                errors++;
                $display("FAIL lfsr_nonzero at %0t: actual=%h/%h/%h required=nonzero", $time,
                         dut.lfsr1_q, dut.lfsr2_q, dut.lfsr3_q);
            end
        end
    end

    // Called at posedge+1; applies bp for n edges and returns at posedge+1.
    task automatic cycles(input bit bp, input int n);
        button_press = bp;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_rng(input string name, input logic [2:0] e1, input logic [2:0] e2,
                             input logic [2:0] e3);
        check({name, "_rng1"}, {5'd0, rng1}, {5'd0, e1});
        check({name, "_rng2"}, {5'd0, rng2}, {5'd0, e2});
        check({name, "_rng3"}, {5'd0, rng3}, {5'd0, e3});
    endtask

    task automatic check_lfsr(input string name, input logic [7:0] e1, input logic [7:0] e2,
                              input logic [7:0] e3);
        check({name, "_lfsr1"}, dut.lfsr1_q, e1);
        check({name, "_lfsr2"}, dut.lfsr2_q, e2);
        check({name, "_lfsr3"}, dut.lfsr3_q, e3);
        check({name, "_model1"}, m_lfsr[0], e1);
        check({name, "_model2"}, m_lfsr[1], e2);
        check({name, "_model3"}, m_lfsr[2], e3);
    endtask

    initial begin
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_en = 1'b1;

        // Reset state, then idle hold.
        check_rng("reset", 3'd0, 3'd0, 3'd0);
        check_lfsr("reset", 8'hA5, 8'h3C, 8'h5A);
        cycles(1'b0, 10);
        check_rng("idle10", 3'd0, 3'd0, 3'd0);

        // First enabled step.
        cycles(1'b1, 1);
        check_rng("step1", 3'd2, 3'd1, 3'd4);
        check_lfsr("step1", 8'h4A, 8'h79, 8'hB4);
        check("guard_lfsr1", dut_z.lfsr1_q, 8'h01);
        check("guard_lfsr2", dut_z.lfsr2_q, 8'h02);
        check("guard_lfsr3", dut_z.lfsr3_q, 8'h01);
        check("guard_rng1", {5'd0, z_rng1}, 8'h01);
        check("guard_rng2", {5'd0, z_rng2}, 8'h02);
        check("guard_rng3", {5'd0, z_rng3}, 8'h01);

        // 50 steps held, then freeze for 10+ idle cycles.
        cycles(1'b1, 49);
        cycles(1'b0, 12);

        // Full period returns to the seeds.
        pulse_reset();
        cycles(1'b1, 255);
        check_lfsr("period", 8'hA5, 8'h3C, 8'h5A);
        check_rng("period", 3'd5, 3'd4, 3'd2);

        // Asynchronous reset between edges during a press.
        cycles(1'b1, 3);
        #1;
        reset = 1'b1;
        #1;
        check_rng("async_reset", 3'd0, 3'd0, 3'd0);
        check("async_reset_lfsr1", dut.lfsr1_q, 8'hA5);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycles(1'b1, 1);
        check_rng("restart", 3'd2, 3'd1, 3'd4);
        check_lfsr("restart", 8'h4A, 8'h79, 8'hB4);

        // Long spin pattern compared every cycle.
        pulse_reset();
        for (int s = 0; s < 24; s++) begin
            cycles(1'b1, 50);
            cycles(1'b0, 10);
        end

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
